// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

  // Bits needed to index WIDTH bit positions; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/adder.sv
// One-bit full adder cell shared by the serial datapath.
module adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands, feeds one bit pair per clock
// through a single full-adder cell, and presents {cout,result} with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the upper sum bits; the newest bit is appended on the fly.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum_c;
  logic             fa_cout_c;
  logic [WIDTH-1:0] sum_next_c;

  adder u_adder (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_c),
    .cout (fa_cout_c)
  );

  assign sum_next_c = {fa_sum_c, s_sr_q};

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    s_sr_d   = s_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = sum_next_c[WIDTH-1:1];
        carry_d = fa_cout_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = sum_next_c;
          cout_d   = fa_cout_c;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      s_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      s_sr_q   <= s_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that sits directly upstream of the team's one-bit full adder `adder`. It captures two parallel operands and a carry-in, then feeds the full adder one bit pair per clock, LSB first. It registers the carry between bits and assembles the sum serially. The parallel result and carry-out are presented with a one-cycle done pulse, which trades latency for a single adder cell.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  WIDTH  operand A, captured on accepted start
- op_b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result/cout valid and new
- result  output  WIDTH  registered sum, stable between operations
- cout  output  1  registered carry-out of bit WIDTH-1

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - On that edge, load shift regs a_sr←op_a and b_sr←op_b.
  - Load carry←cin, bit counter cnt←0.
- Each RUN cycle:
  - Full adder inputs: a=a_sr[0], b=b_sr[0], cin=carry.
  - On the edge: a_sr and b_sr shift right, sum shifts into s_sr MSB, carry←cout, cnt←cnt+1.
- RUN → DONE on the edge that processes bit WIDTH-1 (cnt==WIDTH-1).
  - Same edge loads result←final assembled sum (including that bit) and cout←adder cout.
- DONE → IDLE unconditionally after one cycle.
- busy=1 exactly in RUN; done=1 exactly in DONE.
- start in RUN or DONE is ignored, not queued.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1); no overflow flag.
- result/cout change only on the RUN→DONE edge; they hold through IDLE and the next RUN.

## Timing
- Reset (async assert, sync-released flops):
  - state=IDLE
  - busy=0, done=0, result=0, cout=0
  - cnt=0, carry=0, shift regs=0
- Latency, with start accepted on edge k:
  - busy high from edge k to edge k+WIDTH.
  - done high from edge k+WIDTH to edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. With start held high continuously, the next operation is accepted on the edge after DONE→IDLE, i.e. edge k+WIDTH+2.
- Operand inputs are don't-care except on the accepting edge.
- Reset mid-RUN or mid-DONE:
  - Aborts immediately and returns to the reset state.
  - No done pulse; result/cout cleared to 0.
- WIDTH=2 is the minimum configuration: exactly 2 RUN cycles.

## Structure
- Shared package `serial_adder_pkg`:
  - State enum `sa_state_e` {IDLE, RUN, DONE}.
  - Helper constant/function for counter width, $clog2(WIDTH).
- One sub-module: instance of the existing `adder`.
  - Ports a, b, cin, sum, cout.
  - Driven combinationally from a_sr[0], b_sr[0], carry.
- No other hierarchy; FSM, counter and shift registers are in the top.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, release, no start → busy=0, done=0, result=0, cout=0 indefinitely.
- Basic carry chain: WIDTH=8, op_a=8'hFF, op_b=8'h01, cin=0 → done exactly 8 edges after accepting edge; result=8'h00, cout=1.
- Carry-in use: op_a=8'hA5, op_b=8'h5A, cin=1 → result=8'h00, cout=1. Then op_a=8'h12, op_b=8'h34, cin=0 → result=8'h46, cout=0; previous result held until that done.
- Busy protection: start pulsed with new operands on cycle 3 of RUN → ignored; only first operation's result appears; exactly one done pulse.
- Reset mid-operation: assert rst_n=0 on RUN cycle 4 → outputs zero immediately, no done. After release, new start 8'h01+8'h01 → result=8'h02.
- Back-to-back and random: start held high with 200 random operand sets → consecutive done pulses spaced WIDTH+2 cycles; each {cout,result} equals op_a+op_b+cin. Repeat at WIDTH=2 and WIDTH=16.
